sprite_compositor: RTL and testbench
====================================

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 Parameter NUM_SPR, default 2: number of sprite channels; index 0 is highest priority.
REQ-002 Parameter SPR_SIZE, default 32: sprite edge in pixels, a power of two from 8 to 64.
REQ-003 Parameter AW, default log2(SPR_SIZE*SPR_SIZE): sprite ROM address width.
REQ-004 Parameter KEY_COLOR, default 12'h000: transparent color key.
REQ-005 Parameter WALL_COLOR, default 12'hfff; BG_COLOR, default 12'h000.
REQ-006 Ports, listed as name, direction, width, meaning:
- clk, in, 1: single clock (VGA pixel clock domain).
- rst, in, 1: reset; the reset is asynchronous and active-high.
- pix_valid, in, 1: col_addr/row_addr are valid this cycle.
- col_addr, in, 10: current pixel column.
- row_addr, in, 9: current pixel row.
- frame_start, in, 1: one-cycle pulse at the start of vertical blank.
- over, in, 1: game over; the pixel is forced black.
- is_wall, in, 1: the map reports a wall at the current pixel.
- spr_x, in, NUM_SPR*10: packed sprite X positions, channel i at bits [10i+9:10i].
- spr_y, in, NUM_SPR*9: packed sprite Y positions.
- spr_orient, in, NUM_SPR*2: packed orientation codes.
- spr_en, in, NUM_SPR: sprite enables.
- rom_addr, out, NUM_SPR*AW: per-channel ROM address.
- rom_data, in, NUM_SPR*12: per-channel ROM data, returned one cycle after the address.
- pix_data, out, 12: composited RGB444 pixel.
- pix_valid_out, out, 1: pix_data is valid.
- collision, out, 1: at least one opaque sprite overlap occurred in the previous frame.

Function
REQ-007 spr_x, spr_y, spr_orient and spr_en SHALL be loaded into shadow registers only on a clk edge where frame_start=1; all compositing SHALL use the shadow values, so positions never tear mid-frame.
REQ-008 Hit test for channel i SHALL be: en_i AND X_i <= col < X_i+SPR_SIZE AND Y_i <= row < Y_i+SPR_SIZE.
- Sums use 11-bit (X) and 10-bit (Y) arithmetic, so there is no wrap.
- A sprite partly past col 639 or row 479 SHALL be clipped, never aliased to col 0.
REQ-009 Let dx=col-X_i and dy=row-Y_i, with S=SPR_SIZE. The orientation code SHALL select rom_addr_i:
- 00: dx*S+dy
- 01: dx*S+(S-1-dy)
- 10: dy*S+dx
- 11: dy*S+(S-1-dx)
REQ-010 rom_addr SHALL be combinational from the current inputs and shadow registers. When a channel has no hit, its rom_addr SHALL be 0.
REQ-011 Pipeline stage 1 SHALL register pix_valid, over, is_wall and the per-channel hit vector. The result SHALL be registered at the next edge, giving a fixed latency of 2 cycles from pix_valid to pix_valid_out.
REQ-012 A channel is opaque when hit is set and rom_data_i != KEY_COLOR.
REQ-013 pix_data priority, highest first:
- over -> 12'h000
- is_wall -> WALL_COLOR
- lowest-index opaque channel -> its rom_data
- otherwise -> BG_COLOR
REQ-014 When stage-1 pix_valid is 0, pix_data SHALL hold its previous value and pix_valid_out SHALL be 0.
REQ-015 An internal sticky accumulator SHALL set when stage-1 pix_valid=1 and at least two channels are opaque in the same pixel. is_wall and over do not mask this detection.
REQ-016 On a frame_start edge:
- collision <= accumulator OR the current-cycle detection.
- The accumulator is cleared.
- collision holds its value until the next frame_start.
REQ-017 frame_start asserted together with pix_valid SHALL still composite that pixel, using the pre-update shadow values.
REQ-018 With NUM_SPR=1, collision SHALL be constant 0.

Reset
REQ-019 While rst=1 the following SHALL be 0: shadow registers (all sprites disabled), the pipeline registers, pix_data, pix_valid_out, collision and the accumulator.
REQ-020 rst asserted mid-line SHALL abort the in-flight pixels. The first pix_valid_out after release SHALL be exactly 2 cycles after the first pix_valid.
REQ-021 After reset, sprites SHALL remain invisible until the first frame_start loads the shadow registers.

Verification
REQ-022 Basic render: sprite0 en=1, X=100, Y=50, orient=10, then frame_start; pixel (col 103, row 52) -> rom_addr0=67, and two cycles later pix_data equals rom_data0.
REQ-023 Orientation: same pixel with orient 01 -> rom_addr0=3*32+29=125; with orient 11 -> 2*32+28=92.
REQ-024 Priority and transparency:
- Both sprites at (200,200), rom_data0=KEY_COLOR, rom_data1=12'h0f0 -> pix_data=12'h0f0.
- Same case with rom_data0=12'hf00 -> pix_data=12'hf00 and collision=1 after the next frame_start.
- Same case with is_wall=1 -> pix_data=12'hfff.
REQ-025 Clipping: sprite0 at X=630 -> col 639 hits with dx=9 and col 0 does not hit; over=1 forces 12'h000 on every pixel.
REQ-026 Shadow timing: change spr_x mid-frame -> the output is unchanged until after frame_start; no opaque overlap in a frame -> collision=0 at the following frame_start.
REQ-027 Reset: rst pulsed mid-line -> all outputs 0 immediately, and the latency after release is exactly 2 cycles.

Source files
------------

// File: rtl/sprite_compositor.sv
// Sprite compositor: per-frame shadowed sprite positions, hit test and ROM addressing,
// then a two-stage pipeline that layers sprites, walls and game-over onto the pixel stream.
module sprite_compositor #(
  parameter int unsigned NUM_SPR    = 2,
  parameter int unsigned SPR_SIZE   = 32,
  parameter int unsigned AW         = $clog2(SPR_SIZE * SPR_SIZE),
  parameter logic [11:0] KEY_COLOR  = 12'h000,
  parameter logic [11:0] WALL_COLOR = 12'hfff,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pix_valid,
  input  logic [9:0]              col_addr,
  input  logic [8:0]              row_addr,
  input  logic                    frame_start,
  input  logic                    over,
  input  logic                    is_wall,
  input  logic [NUM_SPR*10-1:0]   spr_x,
  input  logic [NUM_SPR*9-1:0]    spr_y,
  input  logic [NUM_SPR*2-1:0]    spr_orient,
  input  logic [NUM_SPR-1:0]      spr_en,
  output logic [NUM_SPR*AW-1:0]   rom_addr,
  input  logic [NUM_SPR*12-1:0]   rom_data,
  output logic [11:0]             pix_data,
  output logic                    pix_valid_out,
  output logic                    collision
);

  localparam int unsigned LW = $clog2(SPR_SIZE);

  logic [NUM_SPR*10-1:0] sx_q, sx_d;
  logic [NUM_SPR*9-1:0]  sy_q, sy_d;
  logic [NUM_SPR*2-1:0]  so_q, so_d;
  logic [NUM_SPR-1:0]    sen_q, sen_d;

  logic                  v1_q, over1_q, wall1_q;
  logic [NUM_SPR-1:0]    hit, hit1_q;
  logic [11:0]           pix_q, pix_d;
  logic                  pvo_q;
  logic                  acc_q, acc_d, coll_q, coll_d;

  always_comb begin
    sx_d  = sx_q;
    sy_d  = sy_q;
    so_d  = so_q;
    sen_d = sen_q;
    if (frame_start) begin
      sx_d  = spr_x;
      sy_d  = spr_y;
      so_d  = spr_orient;
      sen_d = spr_en;
    end
  end

  // Widened compares so a sprite hanging off the right/bottom edge clips instead of wrapping.
  logic [10:0]       x_lo, x_hi;
  logic [9:0]        y_lo, y_hi;
  logic [LW-1:0]     dxl, dyl;
  logic [2*LW-1:0]   addr;

  always_comb begin
    hit      = '0;
    rom_addr = '0;
    x_lo     = '0;
    x_hi     = '0;
    y_lo     = '0;
    y_hi     = '0;
    dxl      = '0;
    dyl      = '0;
    addr     = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      x_lo = {1'b0, sx_q[i*10 +: 10]};
      x_hi = x_lo + 11'(SPR_SIZE);
      y_lo = {1'b0, sy_q[i*9 +: 9]};
      y_hi = y_lo + 10'(SPR_SIZE);
      hit[i] = sen_q[i] && ({1'b0, col_addr} >= x_lo) && ({1'b0, col_addr} < x_hi) &&
               ({1'b0, row_addr} >= y_lo) && ({1'b0, row_addr} < y_hi);
      dxl = LW'(col_addr) - LW'(sx_q[i*10 +: 10]);
      dyl = LW'(row_addr) - LW'(sy_q[i*9 +: 9]);
      // S-1-d is the bitwise complement of d within LW bits.
      unique case (so_q[i*2 +: 2])
        2'b00:   addr = {dxl, dyl};
        2'b01:   addr = {dxl, ~dyl};
        2'b10:   addr = {dyl, dxl};
        default: addr = {dyl, ~dxl};
      endcase
      if (hit[i]) rom_addr[i*AW +: AW] = AW'(addr);
    end
  end

  logic [NUM_SPR-1:0] opaque;
  logic [11:0]        spr_pix;
  logic               found, seen, two, det;

  always_comb begin
    opaque  = '0;
    spr_pix = BG_COLOR;
    found   = 1'b0;
    seen    = 1'b0;
    two     = 1'b0;
    for (int i = 0; i < NUM_SPR; i++) begin
      opaque[i] = hit1_q[i] && (rom_data[i*12 +: 12] != KEY_COLOR);
      two       = two | (seen & opaque[i]);
      seen      = seen | opaque[i];
    end
    // Walk from the lowest priority up so channel 0 overwrites last.
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        spr_pix = rom_data[i*12 +: 12];
        found   = 1'b1;
      end
    end
    det = v1_q && two;

    pix_d = pix_q;
    if (v1_q) begin
      if (over1_q)      pix_d = 12'h000;
      else if (wall1_q) pix_d = WALL_COLOR;
      else if (found)   pix_d = spr_pix;
      else              pix_d = BG_COLOR;
    end

    acc_d  = frame_start ? 1'b0 : (acc_q | det);
    coll_d = frame_start ? (acc_q | det) : coll_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx_q    <= '0;
      sy_q    <= '0;
      so_q    <= '0;
      sen_q   <= '0;
      v1_q    <= 1'b0;
      over1_q <= 1'b0;
      wall1_q <= 1'b0;
      hit1_q  <= '0;
      pix_q   <= '0;
      pvo_q   <= 1'b0;
      acc_q   <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      so_q    <= so_d;
      sen_q   <= sen_d;
      v1_q    <= pix_valid;
      over1_q <= over;
      wall1_q <= is_wall;
      hit1_q  <= hit;
      pix_q   <= pix_d;
      pvo_q   <= v1_q;
      acc_q   <= acc_d;
      coll_q  <= coll_d;
    end
  end

  assign pix_data      = pix_q;
  assign pix_valid_out = pvo_q;
  assign collision     = coll_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: addressing, orientation, priority, clipping,
// shadow timing, collision reporting and reset behaviour.
module tb_sprite_compositor;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid, frame_start, over, is_wall;
  logic [9:0]  col_addr;
  logic [8:0]  row_addr;
  logic [19:0] spr_x;
  logic [17:0] spr_y;
  logic [3:0]  spr_orient;
  logic [1:0]  spr_en;
  logic [19:0] rom_addr;
  logic [23:0] rom_data;
  logic [11:0] pix_data;
  logic        pix_valid_out, collision;

  int n_cmp = 0;
  int n_bad = 0;

  sprite_compositor dut (
    .clk          (clk),
    .rst          (rst),
    .pix_valid    (pix_valid),
    .col_addr     (col_addr),
    .row_addr     (row_addr),
    .frame_start  (frame_start),
    .over         (over),
    .is_wall      (is_wall),
    .spr_x        (spr_x),
    .spr_y        (spr_y),
    .spr_orient   (spr_orient),
    .spr_en       (spr_en),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .pix_data     (pix_data),
    .pix_valid_out(pix_valid_out),
    .collision    (collision)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // One pixel through the pipe; pix_data/pix_valid_out are ready when this returns.
  task automatic do_pix(input logic [9:0] c, input logic [8:0] r, input logic [11:0] d0,
                        input logic [11:0] d1, input logic w, input logic o);
    col_addr  = c;
    row_addr  = r;
    is_wall   = w;
    over      = o;
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    is_wall   = 1'b0;
    over      = 1'b0;
    rom_data  = {d1, d0};
    tick();
  endtask

  initial begin
    rst = 1'b1;
    pix_valid = 1'b0; frame_start = 1'b0; over = 1'b0; is_wall = 1'b0;
    col_addr = '0; row_addr = '0; rom_data = '0;
    spr_x = '0; spr_y = '0; spr_orient = '0; spr_en = '0;
    tick();
    tick();
    chk("reset_pix_data", 32'(pix_data), 32'h000);
    chk("reset_valid_out", 32'(pix_valid_out), 32'd0);
    chk("reset_collision", 32'(collision), 32'd0);
    rst = 1'b0;
    tick();

    // Sprites invisible before the first frame_start.
    spr_en = 2'b01; spr_x[9:0] = 10'd100; spr_y[8:0] = 9'd50; spr_orient[1:0] = 2'b10;
    col_addr = 10'd103; row_addr = 9'd52;
    #1;
    chk("pre_frame_addr0", 32'(rom_addr[9:0]), 32'd0);
    frame();

    // Basic render, orient 10: dy*32+dx = 2*32+3.
    col_addr = 10'd103; row_addr = 9'd52; pix_valid = 1'b1;
    #1;
    chk("basic_addr0", 32'(rom_addr[9:0]), 32'd67);
    tick();
    pix_valid = 1'b0; rom_data = {12'h000, 12'habc};
    chk("latency_1cyc", 32'(pix_valid_out), 32'd0);
    tick();
    chk("basic_valid", 32'(pix_valid_out), 32'd1);
    chk("basic_pix", 32'(pix_data), 32'habc);
    tick();
    chk("hold_valid", 32'(pix_valid_out), 32'd0);
    chk("hold_pix", 32'(pix_data), 32'habc);

    // Orientations.
    spr_orient[1:0] = 2'b01;
    frame();
    #1;
    chk("orient01_addr", 32'(rom_addr[9:0]), 32'd125);
    spr_orient[1:0] = 2'b11;
    frame();
    #1;
    chk("orient11_addr", 32'(rom_addr[9:0]), 32'd92);

    // Two overlapping sprites at (200,200), orient 00.
    spr_en = 2'b11; spr_orient = 4'b0000;
    spr_x = {10'd200, 10'd200}; spr_y = {9'd200, 9'd200};
    frame();
    col_addr = 10'd205; row_addr = 9'd203;
    #1;
    chk("ch1_addr", 32'(rom_addr[19:10]), 32'd163);
    do_pix(10'd205, 9'd203, 12'h000, 12'h0f0, 1'b0, 1'b0);
    chk("transparent_ch0", 32'(pix_data), 32'h0f0);
    do_pix(10'd205, 9'd203, 12'hf00, 12'h0f0, 1'b0, 1'b0);
    chk("priority_ch0", 32'(pix_data), 32'hf00);
    do_pix(10'd205, 9'd203, 12'hf00, 12'h0f0, 1'b1, 1'b0);
    chk("wall_over_spr", 32'(pix_data), 32'hfff);
    do_pix(10'd0, 9'd0, 12'h123, 12'h456, 1'b0, 1'b0);
    chk("background", 32'(pix_data), 32'h000);
    chk("coll_before_fs", 32'(collision), 32'd0);
    frame();
    chk("coll_after_fs", 32'(collision), 32'd1);
    do_pix(10'd205, 9'd203, 12'h000, 12'h0f0, 1'b0, 1'b0);
    chk("coll_held", 32'(collision), 32'd1);
    frame();
    chk("coll_cleared", 32'(collision), 32'd0);

    // Clipping at the right edge, orient 10.
    spr_en = 2'b01; spr_x[9:0] = 10'd630; spr_y[8:0] = 9'd0; spr_orient[1:0] = 2'b10;
    frame();
    col_addr = 10'd639; row_addr = 9'd0;
    #1;
    chk("clip_addr639", 32'(rom_addr[9:0]), 32'd9);
    col_addr = 10'd0;
    #1;
    chk("clip_addr0", 32'(rom_addr[9:0]), 32'd0);
    do_pix(10'd639, 9'd0, 12'h123, 12'h000, 1'b0, 1'b0);
    chk("clip_pix639", 32'(pix_data), 32'h123);
    do_pix(10'd0, 9'd0, 12'h123, 12'h000, 1'b0, 1'b0);
    chk("clip_pix0", 32'(pix_data), 32'h000);
    do_pix(10'd639, 9'd0, 12'h123, 12'h000, 1'b0, 1'b0);
    do_pix(10'd639, 9'd0, 12'h123, 12'h000, 1'b0, 1'b1);
    chk("over_black", 32'(pix_data), 32'h000);

    // Shadow timing: mid-frame spr_x change has no effect until frame_start.
    spr_x[9:0] = 10'd0;
    do_pix(10'd639, 9'd0, 12'h321, 12'h000, 1'b0, 1'b0);
    chk("shadow_hold_pix", 32'(pix_data), 32'h321);
    frame();
    col_addr = 10'd5; row_addr = 9'd0;
    #1;
    chk("shadow_new_addr", 32'(rom_addr[9:0]), 32'd5);

    // frame_start coincident with pix_valid uses pre-update shadows.
    spr_x[9:0] = 10'd630;
    col_addr = 10'd5; pix_valid = 1'b1; frame_start = 1'b1;
    #1;
    chk("fs_pix_addr", 32'(rom_addr[9:0]), 32'd5);
    tick();
    frame_start = 1'b0; pix_valid = 1'b0; rom_data = {12'h000, 12'h456};
    tick();
    chk("fs_pix_data", 32'(pix_data), 32'h456);
    chk("fs_pix_valid", 32'(pix_valid_out), 32'd1);

    // Reset mid-line aborts in-flight pixels.
    col_addr = 10'd639; pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_pix_data", 32'(pix_data), 32'h000);
    chk("rst_valid_out", 32'(pix_valid_out), 32'd0);
    chk("rst_addr", 32'(rom_addr[9:0]), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 32'(pix_valid_out), 32'd0);
    col_addr = 10'd639; pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0; rom_data = {12'h000, 12'h777};
    chk("post_rst_lat1", 32'(pix_valid_out), 32'd0);
    tick();
    chk("post_rst_lat2", 32'(pix_valid_out), 32'd1);
    chk("post_rst_pix", 32'(pix_data), 32'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
